// File: rtl/rv32_multicycle_core_if.sv
// rtl/rv32_multicycle_core_if.sv - unified instruction/data memory port with req/ready handshake
interface rv32_multicycle_core_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/rv32_multicycle_core.sv
// rtl/rv32_multicycle_core.sv - multi-cycle RV32I/RV32E core on a single shared memory port
// FETCH/DECODE/EXECUTE/MEM/WB/HALT sequencer; all outputs are registered.
module rv32_multicycle_core #(
  parameter int          DATA_WIDTH = 32,
  parameter int          REGF_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  rv32_multicycle_core_if.master mem,
  output logic                   retire,
  output logic                   halted,
  output logic                   illegal,
  output logic [ADDR_WIDTH-1:0]  dbg_pc
);
  localparam int         RI    = $clog2(REGF_DEPTH);
  localparam logic [5:0] DEPTH = 6'(REGF_DEPTH);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("rv32_multicycle_core: DATA_WIDTH must be 32");
  end
  if (REGF_DEPTH != 16 && REGF_DEPTH != 32) begin : g_bad_regf_depth
    $error("rv32_multicycle_core: REGF_DEPTH must be 16 or 32");
  end
  if (ADDR_WIDTH < 2 || ADDR_WIDTH > 32) begin : g_bad_addr_width
    $error("rv32_multicycle_core: ADDR_WIDTH must be 2..32");
  end

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]            imm_q, imm_d, alu_q, alu_d, mdr_q, mdr_d;
  logic                   mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   retire_q, retire_d, halted_q, halted_d, illegal_q, illegal_d;
  logic [31:0]            rf_q [REGF_DEPTH];
  logic                   rf_we;
  logic [RI-1:0]          rf_wa;
  logic [31:0]            rf_wd;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  logic        legal, uses_rs1, uses_rs2, uses_rd, is_env, bad_idx, is_jump;
  logic [31:0] op_b, alu_res, pc_plus4, br_target, jump_target, fetch_pc;
  logic        br_taken, go_fetch, do_halt, halt_ill;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  always_comb begin
    imm_sel  = imm_i;
    legal    = 1'b0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    uses_rd  = 1'b1;
    case (opcode)
      OP_LUI, OP_AUIPC: begin imm_sel = imm_u; legal = 1'b1; uses_rs1 = 1'b0; end
      OP_JAL:           begin imm_sel = imm_j; legal = 1'b1; uses_rs1 = 1'b0; end
      OP_JALR:          legal = (f3 == 3'b000);
      OP_BRANCH: begin
        imm_sel = imm_b; legal = (f3 != 3'b010) && (f3 != 3'b011);
        uses_rs2 = 1'b1; uses_rd = 1'b0;
      end
      OP_LOAD:          legal = (f3 == 3'b010);
      OP_STORE:  begin imm_sel = imm_s; legal = (f3 == 3'b010); uses_rs2 = 1'b1; uses_rd = 1'b0; end
      OP_IMM:           legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                                (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_REG:    begin
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        uses_rs2 = 1'b1;
      end
      default:          legal = 1'b0;
    endcase
  end

  assign is_env  = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
  assign bad_idx = (uses_rd  && {1'b0, rd}  >= DEPTH) ||
                   (uses_rs1 && {1'b0, rs1} >= DEPTH) ||
                   (uses_rs2 && {1'b0, rs2} >= DEPTH);
  assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);

  // Only R-type uses funct7[5] as SUB; in I-type those bits are immediate.
  assign op_b = (opcode == OP_REG || opcode == OP_BRANCH) ? b_q : imm_q;
  always_comb begin
    case (f3)
      3'b000:  alu_res = (opcode == OP_REG && f7[5]) ? a_q - op_b : a_q + op_b;
      3'b001:  alu_res = a_q << op_b[4:0];
      3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op_b)};
      3'b011:  alu_res = {31'b0, a_q < op_b};
      3'b100:  alu_res = a_q ^ op_b;
      3'b101:  alu_res = f7[5] ? 32'($signed(a_q) >>> op_b[4:0]) : a_q >> op_b[4:0];
      3'b110:  alu_res = a_q | op_b;
      default: alu_res = a_q & op_b;
    endcase
    case (opcode)
      OP_LUI:            alu_res = imm_q;
      OP_AUIPC:          alu_res = pc_q + imm_q;
      OP_JAL, OP_JALR:   alu_res = pc_plus4;
      OP_LOAD, OP_STORE: alu_res = a_q + imm_q;
      default: ;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b100:  br_taken = $signed(a_q) <  $signed(b_q);
      3'b101:  br_taken = $signed(a_q) >= $signed(b_q);
      3'b110:  br_taken = a_q <  b_q;
      3'b111:  br_taken = a_q >= b_q;
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4    = pc_q + 32'd4;
  assign br_target   = pc_q + imm_q;
  assign jump_target = (opcode == OP_JAL) ? br_target : ((a_q + imm_q) & ~32'd1);

  always_comb begin
    state_d = state_q; pc_d = pc_q; ir_d = ir_q; a_d = a_q; b_d = b_q;
    imm_d = imm_q; alu_d = alu_q; mdr_d = mdr_q;
    mem_req_d = mem_req_q; mem_we_d = mem_we_q; mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
    retire_d = 1'b0; halted_d = halted_q; illegal_d = illegal_q;
    rf_we = 1'b0; rf_wa = rd[RI-1:0]; rf_wd = alu_q;
    go_fetch = 1'b0; fetch_pc = pc_plus4; do_halt = 1'b0; halt_ill = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1; mem_we_d = 1'b0; mem_addr_d = pc_q[ADDR_WIDTH-1:0];
        end else if (mem.mem_ready) begin
          ir_d = mem.mem_rdata; mem_req_d = 1'b0; state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = rf_q[rs1[RI-1:0]]; b_d = rf_q[rs2[RI-1:0]]; imm_d = imm_sel;
        if (is_env)                 do_halt = 1'b1;
        else if (!legal || bad_idx) begin do_halt = 1'b1; halt_ill = 1'b1; end
        else                        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        alu_d = alu_res;
        if (opcode == OP_BRANCH) begin
          if (br_taken && br_target[1]) begin do_halt = 1'b1; halt_ill = 1'b1; end
          else begin go_fetch = 1'b1; fetch_pc = br_taken ? br_target : pc_plus4; end
        end else if (opcode == OP_LOAD || opcode == OP_STORE) begin
          // A misaligned address never raises mem_req; MEM turns it into a halt.
          state_d = S_MEM; mem_addr_d = alu_res[ADDR_WIDTH-1:0];
          mem_we_d = (opcode == OP_STORE); mem_wdata_d = b_q; mem_req_d = (alu_res[1:0] == 2'b00);
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (alu_q[1:0] != 2'b00) begin
          do_halt = 1'b1; halt_ill = 1'b1;
        end else if (mem_req_q && mem.mem_ready) begin
          if (opcode == OP_STORE) go_fetch = 1'b1;
          else begin mdr_d = mem.mem_rdata; mem_req_d = 1'b0; mem_we_d = 1'b0; state_d = S_WB; end
        end
      end
      S_WB: begin
        if (is_jump && jump_target[1]) begin
          do_halt = 1'b1; halt_ill = 1'b1;
        end else begin
          rf_we = (rd != 5'd0); rf_wd = (opcode == OP_LOAD) ? mdr_q : alu_q;
          go_fetch = 1'b1; fetch_pc = is_jump ? jump_target : pc_plus4;
        end
      end
      default: ;
    endcase
    if (go_fetch) begin
      pc_d = fetch_pc; retire_d = 1'b1; state_d = S_FETCH;
      mem_req_d = 1'b1; mem_we_d = 1'b0; mem_addr_d = fetch_pc[ADDR_WIDTH-1:0];
    end
    if (do_halt) begin
      state_d = S_HALT; halted_d = 1'b1; illegal_d = halt_ill; mem_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH; pc_q <= RESET_PC; ir_q <= '0; a_q <= '0; b_q <= '0;
      imm_q <= '0; alu_q <= '0; mdr_q <= '0;
      mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_addr_q <= RESET_PC[ADDR_WIDTH-1:0]; mem_wdata_q <= '0;
      retire_q <= 1'b0; halted_q <= 1'b0; illegal_q <= 1'b0;
      for (int i = 0; i < REGF_DEPTH; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d; pc_q <= pc_d; ir_q <= ir_d; a_q <= a_d; b_q <= b_d;
      imm_q <= imm_d; alu_q <= alu_d; mdr_q <= mdr_d;
      mem_req_q <= mem_req_d; mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
      retire_q <= retire_d; halted_q <= halted_d; illegal_q <= illegal_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign retire        = retire_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign dbg_pc        = pc_q[ADDR_WIDTH-1:0];
endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
- Parametrised multi-cycle RV32I core. Functionally it is the next generation of the single-cycle datapath.
- One FSM sequences fetch, decode, execute, memory and writeback.
- A single shared instruction/data memory port with a req/ready handshake tolerates wait states.
- Register file, ALU and immediate logic are internal. The block sits under the SoC top and connects directly to a unified memory or bus bridge.

Parameters:
- DATA_WIDTH, 32, datapath and register width; only 32 is legal. Elaboration error otherwise.
- REGF_DEPTH, 32, number of registers. 32 = RV32I, 16 = RV32E. Register indices >= REGF_DEPTH are illegal.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, memory address width. Upper PC bits above ADDR_WIDTH are truncated on output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write (SW), 0 = read (fetch or LW).
- mem_addr  out  ADDR_WIDTH  byte address, word aligned.
- mem_wdata  out  DATA_WIDTH  store data.
- mem_rdata  in  DATA_WIDTH  read data; valid in the cycle mem_ready=1.
- mem_ready  in  1  request accepted/completed this cycle.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped (ECALL/EBREAK or illegal instruction).
- illegal  out  1  set together with halted when the cause is an illegal instruction, or a misaligned data or jump target.
- dbg_pc  out  ADDR_WIDTH  PC of the current instruction.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - state=FETCH, pc=RESET_PC, all registers=0.
  - mem_req=0, mem_we=0, mem_addr=RESET_PC, mem_wdata=0.
  - retire=0, halted=0, illegal=0.
- Reset asserted mid-transaction abandons it immediately. The memory side must tolerate a dropped request.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=pc.
  - Held until mem_ready=1. On that edge ir<=mem_rdata and state->DECODE.
- DECODE:
  - Read rs1/rs2 into A/B and generate the immediate (I/S/B/U/J).
  - Unsupported opcode, or rs/rd index >= REGF_DEPTH -> HALT with illegal=1.
  - ECALL/EBREAK -> HALT with illegal=0.
- EXECUTE:
  - ALU result latched.
  - Branches: compare A/B (BEQ, BNE, BLT, BGE, BLTU, BGEU). Taken -> pc<=pc+imm; not taken -> pc<=pc+4. Then retire, state->FETCH.
  - Loads/stores -> MEM.
  - All other instructions -> WB.
- MEM:
  - addr=A+imm. If addr[1:0]!=0 -> HALT with illegal=1; no bus request is issued.
  - Otherwise mem_req=1, mem_we=(SW), mem_wdata=B; held stable until mem_ready.
  - SW -> retire, pc<=pc+4, state->FETCH. LW -> WB with mdr<=mem_rdata.
- WB:
  - rd<=result (ALU, mdr, pc+4 for JAL/JALR, imm for LUI, pc+imm for AUIPC). Writes to x0 are discarded.
  - pc update: JAL -> pc+imm; JALR -> (A+imm)&~1. Target[1] set -> HALT with illegal=1 and rd not written.
  - Otherwise pc<=pc+4, retire=1, state->FETCH.
- Latency with zero wait states (ready the same cycle as req):
  - ALU and jump instructions: 4 cycles.
  - Branch: 3 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - Each wait cycle adds 1.
- HALT:
  - Terminal until reset. mem_req=0, retire=0. halted and illegal are held.
  - dbg_pc holds the PC of the offending instruction.
- Handshake: while mem_req=1, mem_addr, mem_we and mem_wdata do not change until mem_ready is seen.
- Arithmetic:
  - Add, sub and shifts wrap modulo 2^32. Shift amount is b[4:0]. SRA is sign-extending.
  - SLT is signed; SLTU is unsigned.
  - PC arithmetic wraps at 2^32.

Test Plan:
- Reset with RESET_PC=0x100, zero-wait memory -> first mem_addr=0x100. ADDI x1,x0,5 then ADD x2,x1,x1 -> x2=10; retire pulses 4 cycles apart.
- SW x2,0x40(x0) then LW x3,0x40(x0), with memory inserting 3 wait states per access -> write of 10 to 0x40 observed on the bus; x3=10; address/data held stable through the waits.
- BLT x4=-1 vs x5=1 -> taken, pc=pc+imm. BLTU with the same operands -> not taken, pc+4. Branch retire spacing is 3 cycles.
- JALR x1,x6,3 with x6=0x200 -> pc=0x202 → illegal halt. JALR x1,x6,1 -> pc=0x200, x1=old pc+4.
- LW from address 0x41 -> halted=1, illegal=1, no mem_req asserted; core stays halted. Then reset -> fetch resumes at RESET_PC.
- REGF_DEPTH=16: ADDI x20,x0,1 -> illegal halt. ADDI x0,x0,7 -> x0 remains 0. Reset asserted mid-FETCH wait -> mem_req drops asynchronously.
